fifo_ptr_sync_cmp: RTL and testbench

// Destination-domain pointer synchronizer and status comparator for the async FIFO.

---
 rtl/fifo_sync_pkg.sv | 32 +++
 rtl/fifo_sync_chain.sv | 28 ++
 rtl/fifo_ptr_sync_cmp.sv | 107 ++++++++++
 tb/tb_fifo_ptr_sync_cmp.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_pkg.sv
// Shared types and Gray-code helpers for the async FIFO pointer blocks.
// Helpers work on a fixed maximum width; callers zero-extend narrower pointers.
package fifo_sync_pkg;

  typedef enum logic {
    SYNC_EMPTY = 1'b0,
    SYNC_FULL  = 1'b1
  } sync_mode_e;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // A legal Gray pointer moves by at most one bit per destination cycle.
  function automatic logic gray_multi_step(input ptr_word_t prev, input ptr_word_t cur);
    return $countones(prev ^ cur) > 1;
  endfunction

endpackage

// File: rtl/fifo_sync_chain.sv
// Plain multi-flop synchronizer for a Gray pointer crossing clock domains.
// No logic between stages so each stage has a full period to resolve.
module fifo_sync_chain #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage [STAGES];

  // NOTE: the stage array is a handful of flops, not a RAM, so every entry is
  // reset; leaving them unreset would let stale pointers escape after reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_ptr_sync_cmp.sv
// Destination-domain pointer synchronizer and empty/full comparator for the async FIFO.
// Also reports fill level, an almost flag and a sticky Gray-coherency error.
module fifo_ptr_sync_cmp
  import fifo_sync_pkg::*;
#(
  parameter int ADDR_WIDTH    = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int MODE          = 0,
  parameter int ALMOST_THRESH = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [ADDR_WIDTH:0] remote_gptr_in,
  input  logic [ADDR_WIDTH:0] local_bptr_in,
  input  logic                err_clr_in,
  output logic [ADDR_WIDTH:0] sync_gptr_out,
  output logic [ADDR_WIDTH:0] sync_bptr_out,
  output logic                flag_out,
  output logic                almost_out,
  output logic [ADDR_WIDTH:0] level_out,
  output logic                sync_ready_out,
  output logic                gray_err_out
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam sync_mode_e MODE_E = (MODE == 1) ? SYNC_FULL : SYNC_EMPTY;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] THR_LO  = PW'(ALMOST_THRESH);
  localparam logic [PW-1:0] THR_HI  = PW'(DEPTH - ALMOST_THRESH);

  logic [PW-1:0] bin_d;
  logic [PW-1:0] level_d;
  logic          flag_d;
  logic          almost_d;
  logic [PW-1:0] prev_gptr;
  logic [2:0]    ready_cnt;
  logic          ready_d;
  logic          err_set;

  fifo_sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_chain (
    .clk    (clk),
    .resetn (resetn),
    .d      (remote_gptr_in),
    .q      (sync_gptr_out)
  );

  // Conversion feeds both the binary register and the comparator so all
  // status outputs update on the same edge as sync_bptr_out.
  assign bin_d = PW'(gray2bin(PTR_MAX_W'(sync_gptr_out)));

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    level_d  = '0;
    flag_d   = 1'b0;
    almost_d = 1'b0;
    if (MODE_E == SYNC_EMPTY) begin
      level_d  = bin_d - local_bptr_in;
      flag_d   = (bin_d == local_bptr_in);
      almost_d = (level_d <= THR_LO);
    end else begin
      level_d  = local_bptr_in - bin_d;
      flag_d   = (bin_d[PW-1] != local_bptr_in[PW-1]) &&
                 (bin_d[PW-2:0] == local_bptr_in[PW-2:0]);
      almost_d = (level_d >= THR_HI);
    end
  end

  // Ready is looked at one edge early so flags release on the same edge it rises.
  assign ready_d = sync_ready_out | (ready_cnt == 3'(SYNC_STAGES));

  // During priming the chain still carries reset zeros, so the check waits for ready.
  assign err_set = sync_ready_out &&
                   (gray_multi_step(PTR_MAX_W'(prev_gptr), PTR_MAX_W'(sync_gptr_out)) ||
                    (level_d > DEPTH_P));

  // NOTE: non-blocking assignments keep every register sampling pre-edge
  // values, independent of statement order inside this block.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_bptr_out  <= '0;
      level_out      <= '0;
      flag_out       <= 1'b1;
      almost_out     <= 1'b1;
      sync_ready_out <= 1'b0;
      ready_cnt      <= '0;
      prev_gptr      <= '0;
      gray_err_out   <= 1'b0;
    end else begin
      sync_bptr_out  <= bin_d;
      level_out      <= level_d;
      flag_out       <= ready_d ? flag_d   : 1'b1;
      almost_out     <= ready_d ? almost_d : 1'b1;
      sync_ready_out <= ready_d;
      if (ready_cnt != 3'(SYNC_STAGES)) ready_cnt <= ready_cnt + 3'd1;
      prev_gptr      <= sync_gptr_out;
      gray_err_out   <= err_set | (gray_err_out & ~err_clr_in);
    end
  end

endmodule

// File: tb/tb_fifo_ptr_sync_cmp.sv
// Scoreboard bench: one read-side (MODE 0) and one write-side (MODE 1) instance,
// directed pointer sequences with hand-computed expectations checked by cycle.
module tb_fifo_ptr_sync_cmp;

  logic clk;
  int   cyc = 0;

  logic [1:0] rstn;
  logic [1:0] clr;
  logic [4:0] rgp [2];
  logic [4:0] lbp [2];

  logic [1:0] flag, almost, rdy, err;
  logic [4:0] lvl [2];
  logic [4:0] sg  [2];
  logic [4:0] sb  [2];

  fifo_ptr_sync_cmp #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .MODE(0), .ALMOST_THRESH(2)) dut0 (
    .clk(clk), .resetn(rstn[0]), .remote_gptr_in(rgp[0]), .local_bptr_in(lbp[0]),
    .err_clr_in(clr[0]), .sync_gptr_out(sg[0]), .sync_bptr_out(sb[0]), .flag_out(flag[0]),
    .almost_out(almost[0]), .level_out(lvl[0]), .sync_ready_out(rdy[0]), .gray_err_out(err[0])
  );

  fifo_ptr_sync_cmp #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .MODE(1), .ALMOST_THRESH(2)) dut1 (
    .clk(clk), .resetn(rstn[1]), .remote_gptr_in(rgp[1]), .local_bptr_in(lbp[1]),
    .err_clr_in(clr[1]), .sync_gptr_out(sg[1]), .sync_bptr_out(sb[1]), .flag_out(flag[1]),
    .almost_out(almost[1]), .level_out(lvl[1]), .sync_ready_out(rdy[1]), .gray_err_out(err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {F_FLAG, F_ALMOST, F_LEVEL, F_READY, F_ERR, F_SGPTR, F_SBPTR} field_e;
  typedef struct {
    int     cyc;
    int     inst;
    field_e fld;
    int     val;
    string  name;
  } exp_t;

  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [4:0] gray(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int actual(input int inst, input field_e f);
    case (f)
      F_FLAG:   return int'(flag[inst]);
      F_ALMOST: return int'(almost[inst]);
      F_LEVEL:  return int'(lvl[inst]);
      F_READY:  return int'(rdy[inst]);
      F_ERR:    return int'(err[inst]);
      F_SGPTR:  return int'(sg[inst]);
      default:  return int'(sb[inst]);
    endcase
  endfunction

  task automatic check(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (dut%0d, cycle %0d): got %0d, expected %0d", name, inst, cyc, act, exp);
    end
  endtask

  // Expectation for the value visible after edge number cyc+dly.
  task automatic expect_at(input int dly, input int inst, input field_e f, input int v,
                           input string name);
    exp_t e;
    int   i;
    e.cyc  = cyc + dly;
    e.inst = inst;
    e.fld  = f;
    e.val  = v;
    e.name = name;
    i = sb_q.size();
    while (i > 0 && sb_q[i-1].cyc > e.cyc) i--;
    sb_q.insert(i, e);
  endtask

  task automatic expect_reset(input int dly, input int inst, input string tag);
    expect_at(dly, inst, F_FLAG,   1, {tag, "_flag"});
    expect_at(dly, inst, F_ALMOST, 1, {tag, "_almost"});
    expect_at(dly, inst, F_LEVEL,  0, {tag, "_level"});
    expect_at(dly, inst, F_READY,  0, {tag, "_ready"});
    expect_at(dly, inst, F_ERR,    0, {tag, "_err"});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compares whatever expectations fall due at this sample point.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s (dut%0d): due at cycle %0d, sampled late at %0d", e.name, e.inst, e.cyc, cyc);
        end else begin
          check(e.name, e.inst, actual(e.inst, e.fld), e.val);
        end
      end
    end
  end

  initial begin
    rstn = 2'b00;
    clr  = 2'b00;
    rgp[0] = '0; rgp[1] = '0;
    lbp[0] = '0; lbp[1] = '0;

    // Reset in both modes, then ready after the third edge following release.
    expect_reset(2, 0, "rst0");
    expect_reset(2, 1, "rst1");
    wait_cyc(3);
    rstn = 2'b11;
    expect_at(2, 0, F_READY, 0, "ready_low_e2_m0");
    expect_at(2, 1, F_READY, 0, "ready_low_e2_m1");
    expect_at(2, 1, F_FLAG,  1, "full_forced_before_ready");
    expect_at(3, 0, F_READY, 1, "ready_e3_m0");
    expect_at(3, 1, F_READY, 1, "ready_e3_m1");
    expect_at(3, 1, F_FLAG,  0, "full_released_at_ready");
    expect_at(3, 1, F_ALMOST, 0, "almost_full_released");
    expect_at(3, 0, F_FLAG,  1, "empty_at_ready");
    wait_cyc(4);

    // Latency through a two-stage chain.
    rgp[0] = gray(1);
    expect_at(1, 0, F_SGPTR, 0, "lat_sg_edge_k");
    expect_at(2, 0, F_SGPTR, 1, "lat_sg_edge_k1");
    expect_at(2, 0, F_SBPTR, 0, "lat_sb_edge_k1");
    expect_at(2, 0, F_LEVEL, 0, "lat_level_edge_k1");
    expect_at(3, 0, F_SBPTR, 1, "lat_sb_edge_k2");
    expect_at(3, 0, F_LEVEL, 1, "lat_level_edge_k2");
    expect_at(3, 0, F_FLAG,  0, "lat_empty_clears");
    expect_at(3, 0, F_ALMOST, 1, "lat_almost_empty");
    wait_cyc(5);

    // Read side, threshold 2, local pointer 5.
    rstn[0] = 1'b0; rgp[0] = gray(5); lbp[0] = 5'd5;
    wait_cyc(1);
    rstn[0] = 1'b1;
    expect_at(3, 0, F_READY, 1, "m0_ready");
    expect_at(3, 0, F_SBPTR, 5, "m0_sbptr5");
    expect_at(3, 0, F_LEVEL, 0, "m0_level0");
    expect_at(3, 0, F_FLAG,  1, "m0_empty_equal");
    wait_cyc(3);
    rgp[0] = gray(6);
    expect_at(3, 0, F_LEVEL, 1, "m0_level1");
    wait_cyc(1);
    rgp[0] = gray(7);
    expect_at(3, 0, F_LEVEL,  2, "m0_level2");
    expect_at(3, 0, F_FLAG,   0, "m0_not_empty");
    expect_at(3, 0, F_ALMOST, 1, "m0_almost_at_thresh");
    wait_cyc(1);
    rgp[0] = gray(8);
    expect_at(3, 0, F_LEVEL,  3, "m0_level3");
    expect_at(3, 0, F_ALMOST, 0, "m0_almost_above_thresh");
    expect_at(4, 0, F_ERR,    0, "m0_no_err_single_steps");
    wait_cyc(5);

    // Write side: full at level 16, then one read frees a slot.
    rstn[1] = 1'b0; rgp[1] = gray(3); lbp[1] = 5'd19;
    wait_cyc(1);
    rstn[1] = 1'b1;
    expect_at(3, 1, F_LEVEL,  16, "m1_level16");
    expect_at(3, 1, F_FLAG,   1,  "m1_full");
    expect_at(3, 1, F_ALMOST, 1,  "m1_almost_full16");
    wait_cyc(3);
    rgp[1] = gray(4);
    expect_at(3, 1, F_LEVEL,  15, "m1_level15");
    expect_at(3, 1, F_FLAG,   0,  "m1_not_full");
    expect_at(3, 1, F_ALMOST, 1,  "m1_almost_full15");
    wait_cyc(5);

    // Local pointer wraps 31 -> 0 with the read pointer at 17.
    rstn[1] = 1'b0; rgp[1] = gray(17); lbp[1] = 5'd31;
    wait_cyc(1);
    rstn[1] = 1'b1;
    expect_at(3, 1, F_LEVEL,  14, "m1_level14");
    expect_at(3, 1, F_ALMOST, 1,  "m1_almost_at_boundary");
    wait_cyc(4);
    lbp[1] = 5'd0;
    expect_at(1, 1, F_LEVEL, 15, "m1_level15_wrap");
    expect_at(1, 1, F_FLAG,  0,  "m1_not_full_wrap");
    expect_at(2, 1, F_ERR,   0,  "m1_no_err_wrap");
    wait_cyc(3);

    // Mid-operation reset at level 9.
    lbp[1] = 5'd26;
    expect_at(1, 1, F_LEVEL, 9, "m1_level9");
    wait_cyc(2);
    rstn[1] = 1'b0;
    expect_reset(1, 1, "midrst");
    expect_at(1, 1, F_SGPTR, 0, "midrst_sgptr");
    expect_at(1, 1, F_SBPTR, 0, "midrst_sbptr");
    wait_cyc(1);
    rstn[1] = 1'b1;
    expect_at(1, 1, F_FLAG,  1, "midrst_full_e1");
    expect_at(2, 1, F_FLAG,  1, "midrst_full_e2");
    expect_at(2, 1, F_READY, 0, "midrst_ready_e2");
    expect_at(3, 1, F_READY, 1, "midrst_ready_e3");
    expect_at(3, 1, F_FLAG,  0, "midrst_full_release");
    expect_at(3, 1, F_LEVEL, 9, "midrst_level9");
    expect_at(4, 1, F_ERR,   0, "midrst_no_err");
    wait_cyc(6);

    // Gray error: two-bit step, hold, clear, and clear losing to a new error.
    rstn[0] = 1'b0; rgp[0] = gray(3); lbp[0] = 5'd0;
    wait_cyc(1);
    rstn[0] = 1'b1;
    expect_at(3, 0, F_LEVEL, 3, "gerr_level3");
    wait_cyc(4);
    rgp[0] = 5'b01011;
    expect_at(2, 0, F_ERR,   0,  "gerr_not_yet");
    expect_at(3, 0, F_ERR,   1,  "gerr_set");
    expect_at(3, 0, F_LEVEL, 13, "gerr_level_keeps_running");
    expect_at(5, 0, F_ERR,   1,  "gerr_held");
    wait_cyc(6);
    clr[0] = 1'b1;
    expect_at(1, 0, F_ERR, 0, "gerr_cleared");
    wait_cyc(1);
    clr[0] = 1'b0;
    expect_at(1, 0, F_ERR, 0, "gerr_stays_clear");
    wait_cyc(3);
    rgp[0] = 5'b00000;
    expect_at(3, 0, F_ERR, 1, "gerr_step_a");
    wait_cyc(1);
    rgp[0] = 5'b01011;
    wait_cyc(2);
    clr[0] = 1'b1;
    expect_at(1, 0, F_ERR, 1, "gerr_new_beats_clear");
    wait_cyc(1);
    clr[0] = 1'b0;
    expect_at(1, 0, F_ERR, 1, "gerr_after_race");
    wait_cyc(2);
    clr[0] = 1'b1;
    expect_at(1, 0, F_ERR, 0, "gerr_final_clear");
    wait_cyc(1);
    clr[0] = 1'b0;
    wait_cyc(4);

    #1;
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s (dut%0d): expectation for cycle %0d never sampled", e.name, e.inst, e.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
